// File: rtl/traffic_pkg.sv
// Shared definitions for the T-junction conflict monitor: light codes,
// fault codes, lane indices, the lane conflict matrix and small helpers.
package traffic_pkg;

    localparam int NUM_LANES = 6;

    // Controller light codes
    localparam logic [2:0] LIGHT_RED        = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW     = 3'b010;
    localparam logic [2:0] LIGHT_GREEN      = 3'b001;
    localparam logic [2:0] LIGHT_RED_YELLOW = 3'b110;
    localparam logic [2:0] LIGHT_DARK       = 3'b000;

    // Fault causes; the numeric order is also the reporting priority
    typedef enum logic [2:0] {
        FAULT_NONE         = 3'd0,
        FAULT_ILLEGAL_CODE = 3'd1,
        FAULT_CONFLICT     = 3'd2,
        FAULT_BAD_SEQ      = 3'd3,
        FAULT_SHORT_DWELL  = 3'd4
    } fault_code_e;

    // Half-period of the fault flash
    typedef enum logic {
        FLASH_RED  = 1'b0,
        FLASH_DARK = 1'b1
    } flash_phase_e;

    // Lane indices
    localparam logic [2:0] LANE_W_TO_E = 3'd0;
    localparam logic [2:0] LANE_W_TO_N = 3'd1;
    localparam logic [2:0] LANE_E_TO_W = 3'd2;
    localparam logic [2:0] LANE_E_TO_N = 3'd3;
    localparam logic [2:0] LANE_N_TO_E = 3'd4;
    localparam logic [2:0] LANE_N_TO_W = 3'd5;

    // CONFLICT_MATRIX[i][j] is set when lanes i and j may not be active together.
    // Conflicting pairs: 0-4, 1-2, 1-3, 1-4, 2-4, 2-5 (matrix is symmetric).
    localparam logic [NUM_LANES-1:0][NUM_LANES-1:0] CONFLICT_MATRIX = {
        6'b000100,  // lane 5
        6'b000111,  // lane 4
        6'b000010,  // lane 3
        6'b110010,  // lane 2
        6'b011100,  // lane 1
        6'b010000   // lane 0
    };

    function automatic logic is_legal_code(input logic [2:0] code);
        return (code == LIGHT_RED) || (code == LIGHT_YELLOW) ||
               (code == LIGHT_GREEN) || (code == LIGHT_RED_YELLOW);
    endfunction

    function automatic logic is_legal_step(input logic [2:0] from_code, input logic [2:0] to_code);
        return ((from_code == LIGHT_RED)        && (to_code == LIGHT_RED_YELLOW)) ||
               ((from_code == LIGHT_RED_YELLOW) && (to_code == LIGHT_GREEN))      ||
               ((from_code == LIGHT_GREEN)      && (to_code == LIGHT_YELLOW))     ||
               ((from_code == LIGHT_YELLOW)     && (to_code == LIGHT_RED));
    endfunction

    // Index of the lowest set bit; 0 when none is set
    function automatic logic [2:0] first_lane(input logic [NUM_LANES-1:0] vec);
        logic [2:0] lane;
        lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (vec[i]) lane = 3'(i);
        end
        return lane;
    endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// Light bus between the junction controller (master) and the conflict
// monitor (slave): six controller codes in, six lamp drives and fault status out.
interface traffic_conflict_monitor_if;

    logic [2:0] w_to_e_in;
    logic [2:0] w_to_n_in;
    logic [2:0] e_to_w_in;
    logic [2:0] e_to_n_in;
    logic [2:0] n_to_e_in;
    logic [2:0] n_to_w_in;
    logic       fault_clr;

    logic [2:0] w_to_e;
    logic [2:0] w_to_n;
    logic [2:0] e_to_w;
    logic [2:0] e_to_n;
    logic [2:0] n_to_e;
    logic [2:0] n_to_w;
    logic       fault;
    logic [2:0] fault_code;
    logic [2:0] fault_lane;

    modport master (
        output w_to_e_in, w_to_n_in, e_to_w_in, e_to_n_in, n_to_e_in, n_to_w_in, fault_clr,
        input  w_to_e, w_to_n, e_to_w, e_to_n, n_to_e, n_to_w, fault, fault_code, fault_lane
    );

    modport slave (
        input  w_to_e_in, w_to_n_in, e_to_w_in, e_to_n_in, n_to_e_in, n_to_w_in, fault_clr,
        output w_to_e, w_to_n, e_to_w, e_to_n, n_to_e, n_to_w, fault, fault_code, fault_lane
    );

endinterface

// File: rtl/traffic_lane_checker.sv
// Per-lane checker: registers the controller code (cur/prev) and flags
// illegal codes, illegal phase steps and, when TRAFFIC_MONITOR_DWELL_CHECK_EN
// is defined, aspects left before their minimum dwell.
module traffic_lane_checker
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 25_000_000,
    parameter int MIN_AMBER = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_code,
    output logic [2:0] o_cur,
    output logic       o_illegal,
    output logic       o_bad_seq,
    output logic       o_short_dwell
);

    logic [2:0] r_cur;
    logic [2:0] r_prev;
    logic       w_changed;

    // Capture the controller code and keep one cycle of history
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so r_prev sees the old r_cur.
        if (!rst_n) begin
            r_cur  <= LIGHT_RED;
            r_prev <= LIGHT_RED;
        end else begin
            r_cur  <= i_code;
            r_prev <= r_cur;
        end
    end

    assign w_changed = (r_cur != r_prev);
    assign o_cur     = r_cur;
    assign o_illegal = !is_legal_code(r_cur);
    // Sequence is only judged between two legal codes
    assign o_bad_seq = w_changed && is_legal_code(r_cur) && is_legal_code(r_prev) &&
                       !is_legal_step(r_prev, r_cur);

`ifdef TRAFFIC_MONITOR_DWELL_CHECK_EN
    localparam int DWELL_MAX = (MIN_GREEN > MIN_AMBER) ? MIN_GREEN : MIN_AMBER;
    localparam int DWELL_W   = $clog2(DWELL_MAX) + 1;

    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_min;

    // Count how long prev has been held; restart on each change of cur
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
        end else if (w_changed) begin
            r_dwell <= DWELL_W'(1);
        end else if (r_dwell != DWELL_W'(DWELL_MAX)) begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    // Minimum hold time of the aspect being left
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_dwell_min = '0;
        case (r_prev)
            LIGHT_GREEN:                   w_dwell_min = DWELL_W'(MIN_GREEN);
            LIGHT_YELLOW, LIGHT_RED_YELLOW: w_dwell_min = DWELL_W'(MIN_AMBER);
            default:                       w_dwell_min = '0;
        endcase
    end

    assign o_short_dwell = w_changed && (r_dwell < w_dwell_min);
`else
    logic w_unused_cfg;
    assign w_unused_cfg  = ^{MIN_GREEN, MIN_AMBER};
    assign o_short_dwell = 1'b0;
`endif

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor and lamp driver for the six T-junction light buses.
// Lamps follow the controller until the first violation, then a fault is
// latched (cause + lane) and all lamps flash RED/dark until a clean clear.
// Optional minimum-dwell checking: define TRAFFIC_MONITOR_DWELL_CHECK_EN.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 25_000_000,
    parameter int MIN_AMBER = 25_000_000,
    parameter int FLASH_DIV = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    traffic_conflict_monitor_if.slave  io_bus
);

    localparam int FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    logic [2:0]           w_code_in [NUM_LANES];
    logic [2:0]           w_cur     [NUM_LANES];
    logic [2:0]           w_lamp    [NUM_LANES];
    logic [NUM_LANES-1:0] w_illegal;
    logic [NUM_LANES-1:0] w_bad_seq;
    logic [NUM_LANES-1:0] w_short_dwell;
    logic [NUM_LANES-1:0] w_active;
    logic [NUM_LANES-1:0] w_conflict;
    logic                 w_all_red;
    fault_code_e          w_viol_code;
    logic [2:0]           w_viol_lane;
    logic                 w_violation;
    logic                 w_clear_ok;

    logic                 r_fault;
    fault_code_e          r_fault_code;
    logic [2:0]           r_fault_lane;
    logic [FLASH_W-1:0]   r_flash_cnt;
    flash_phase_e         r_flash_phase;

    assign w_code_in[LANE_W_TO_E] = io_bus.w_to_e_in;
    assign w_code_in[LANE_W_TO_N] = io_bus.w_to_n_in;
    assign w_code_in[LANE_E_TO_W] = io_bus.e_to_w_in;
    assign w_code_in[LANE_E_TO_N] = io_bus.e_to_n_in;
    assign w_code_in[LANE_N_TO_E] = io_bus.n_to_e_in;
    assign w_code_in[LANE_N_TO_W] = io_bus.n_to_w_in;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        traffic_lane_checker #(
            .MIN_GREEN (MIN_GREEN),
            .MIN_AMBER (MIN_AMBER)
        ) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_code        (w_code_in[g]),
            .o_cur         (w_cur[g]),
            .o_illegal     (w_illegal[g]),
            .o_bad_seq     (w_bad_seq[g]),
            .o_short_dwell (w_short_dwell[g])
        );
        assign w_active[g] = (w_cur[g] != LIGHT_RED);
    end

    // Flag the lower lane of every conflicting pair that is active together
    always_comb begin
        w_conflict = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = i + 1; j < NUM_LANES; j++) begin
                if (CONFLICT_MATRIX[i][j] && w_active[i] && w_active[j]) w_conflict[i] = 1'b1;
            end
        end
    end

    // Lowest fault code wins, then lowest lane
    always_comb begin
        w_viol_code = FAULT_NONE;
        w_viol_lane = '0;
        if (|w_illegal) begin
            w_viol_code = FAULT_ILLEGAL_CODE;
            w_viol_lane = first_lane(w_illegal);
        end else if (|w_conflict) begin
            w_viol_code = FAULT_CONFLICT;
            w_viol_lane = first_lane(w_conflict);
        end else if (|w_bad_seq) begin
            w_viol_code = FAULT_BAD_SEQ;
            w_viol_lane = first_lane(w_bad_seq);
        end else if (|w_short_dwell) begin
            w_viol_code = FAULT_SHORT_DWELL;
            w_viol_lane = first_lane(w_short_dwell);
        end
    end

    // A clear is honoured only on an all-RED, violation-free cycle
    always_comb begin
        w_all_red = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_cur[i] != LIGHT_RED) w_all_red = 1'b0;
        end
    end

    assign w_violation = (w_viol_code != FAULT_NONE);
    assign w_clear_ok  = io_bus.fault_clr && w_all_red && !w_violation;

    // Latch the first violation; later ones are ignored until a clean clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault      <= 1'b0;
            r_fault_code <= FAULT_NONE;
            r_fault_lane <= '0;
        end else if (!r_fault) begin
            if (w_violation) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_viol_code;
                r_fault_lane <= w_viol_lane;
            end
        end else if (w_clear_ok) begin
            r_fault      <= 1'b0;
            r_fault_code <= FAULT_NONE;
            r_fault_lane <= '0;
        end
    end

    // Flash generator: held at RED/0 while healthy so it starts fresh on a fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flash_cnt   <= '0;
            r_flash_phase <= FLASH_RED;
        end else if (!r_fault) begin
            r_flash_cnt   <= '0;
            r_flash_phase <= FLASH_RED;
        end else if (r_flash_cnt == FLASH_W'(FLASH_DIV - 1)) begin
            r_flash_cnt   <= '0;
            r_flash_phase <= (r_flash_phase == FLASH_RED) ? FLASH_DARK : FLASH_RED;
        end else begin
            r_flash_cnt   <= r_flash_cnt + 1'b1;
        end
    end

    // Lamp mux: follow the controller, or flash when faulted
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            w_lamp[i] = w_cur[i];
            if (r_fault) w_lamp[i] = (r_flash_phase == FLASH_RED) ? LIGHT_RED : LIGHT_DARK;
        end
    end

    assign io_bus.w_to_e     = w_lamp[LANE_W_TO_E];
    assign io_bus.w_to_n     = w_lamp[LANE_W_TO_N];
    assign io_bus.e_to_w     = w_lamp[LANE_E_TO_W];
    assign io_bus.e_to_n     = w_lamp[LANE_E_TO_N];
    assign io_bus.n_to_e     = w_lamp[LANE_N_TO_E];
    assign io_bus.n_to_w     = w_lamp[LANE_N_TO_W];
    assign io_bus.fault      = r_fault;
    assign io_bus.fault_code = r_fault_code;
    assign io_bus.fault_lane = r_fault_lane;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Self-checking bench for traffic_conflict_monitor. Expected outputs are
// queued as each cycle's stimulus is driven and compared after the edge.
// Works with or without TRAFFIC_MONITOR_DWELL_CHECK_EN.
module tb_traffic_conflict_monitor;
    import traffic_pkg::*;

    localparam int MIN_GREEN = 4;
    localparam int MIN_AMBER = 2;
    localparam int FLASH_DIV = 3;
    localparam logic [17:0] ALL_RED = {6{3'b100}};

`ifdef TRAFFIC_MONITOR_DWELL_CHECK_EN
    localparam bit DWELL_EN = 1'b1;
`else
    localparam bit DWELL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [17:0] lamps;
        logic        fault;
        logic [2:0]  code;
        logic [2:0]  lane;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] drv_lanes = ALL_RED;
    logic        drv_clr = 1'b0;
    int          checks = 0;
    int          failures = 0;
    obs_t        sb[$];

    traffic_conflict_monitor_if bus ();

    assign bus.w_to_e_in = drv_lanes[2:0];
    assign bus.w_to_n_in = drv_lanes[5:3];
    assign bus.e_to_w_in = drv_lanes[8:6];
    assign bus.e_to_n_in = drv_lanes[11:9];
    assign bus.n_to_e_in = drv_lanes[14:12];
    assign bus.n_to_w_in = drv_lanes[17:15];
    assign bus.fault_clr = drv_clr;

    traffic_conflict_monitor #(
        .MIN_GREEN (MIN_GREEN),
        .MIN_AMBER (MIN_AMBER),
        .FLASH_DIV (FLASH_DIV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want completion within 200000 time units");
        $fatal(1);
    end

    function automatic logic [17:0] set_lane(input logic [17:0] v, input int lane, input logic [2:0] code);
        logic [17:0] r;
        r = v;
        r[lane*3 +: 3] = code;
        return r;
    endfunction

    // Age counts cycles since the fault rose: RED for FLASH_DIV, then dark for FLASH_DIV
    function automatic logic [17:0] flash_lamps(input int age);
        return (((age / FLASH_DIV) % 2) == 0) ? ALL_RED : 18'd0;
    endfunction

    function automatic obs_t exp_ok(input logic [17:0] lamps);
        return {lamps, 1'b0, 3'd0, 3'd0};
    endfunction

    function automatic obs_t exp_fault(input int age, input logic [2:0] code, input logic [2:0] lane);
        return {flash_lamps(age), 1'b1, code, lane};
    endfunction

    function automatic obs_t observed();
        return {bus.n_to_w, bus.n_to_e, bus.e_to_n, bus.e_to_w, bus.w_to_n, bus.w_to_e,
                bus.fault, bus.fault_code, bus.fault_lane};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("lamps=%05h fault=%0b code=%0d lane=%0d", o.lamps, o.fault, o.code, o.lane);
    endfunction

    task automatic drive_cycle(input logic [17:0] lanes, input logic clr, input obs_t expected);
        drv_lanes = lanes;
        drv_clr   = clr;
        sb.push_back(expected);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        drv_lanes = ALL_RED;
        drv_clr   = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        rst_n     = 1'b0;
        drv_lanes = {6{3'b001}};
        drv_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(exp_ok(ALL_RED));
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_hold: got %s, want %s", fmt(got), fmt(want));
        end
        drv_lanes = ALL_RED;
        #2 rst_n = 1'b1;
        drive_cycle(ALL_RED, 1'b0, exp_ok(ALL_RED));
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_release: got %s, want %s", fmt(got), fmt(want));
        end
    endtask

    // Phases {0,2}, {1,5}, {3,4}: RY x5, GREEN x5, YELLOW x5, RED x1
    task automatic test_legal_cycle();
        int          lane_a [3] = '{0, 1, 3};
        int          lane_b [3] = '{2, 5, 4};
        logic [2:0]  codes  [4] = '{LIGHT_RED_YELLOW, LIGHT_GREEN, LIGHT_YELLOW, LIGHT_RED};
        int          holds  [4] = '{5, 5, 5, 1};
        logic [17:0] v;
        obs_t        got, want;
        int          n = 0;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 4; c++) begin
                for (int h = 0; h < holds[c]; h++) begin
                    v = set_lane(set_lane(ALL_RED, lane_a[p], codes[c]), lane_b[p], codes[c]);
                    drive_cycle(v, 1'b0, exp_ok(v));
                    got = observed(); want = sb.pop_front(); checks++;
                    if (got !== want) begin
                        failures++;
                        $display("FAIL legal[%0d]: got %s, want %s", n, fmt(got), fmt(want));
                    end
                    n++;
                end
            end
        end
    endtask

    task automatic test_conflict();
        logic [17:0] v;
        obs_t        got, want;
        do_reset();
        v = set_lane(set_lane(ALL_RED, 1, LIGHT_GREEN), 3, LIGHT_RED_YELLOW);
        for (int s = 0; s < 11; s++) begin
            drive_cycle(v, 1'b0, (s == 0) ? exp_ok(v) : exp_fault(s - 1, 3'd2, 3'd1));
            got = observed(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL conflict[%0d]: got %s, want %s", s, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_bad_seq_illegal();
        logic [17:0] v;
        obs_t        got, want;
        do_reset();
        v = set_lane(set_lane(ALL_RED, 4, LIGHT_GREEN), 2, 3'b011);
        for (int s = 0; s < 4; s++) begin
            drive_cycle(v, 1'b0, (s == 0) ? exp_ok(v) : exp_fault(s - 1, 3'd1, 3'd2));
            got = observed(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL illegal_priority[%0d]: got %s, want %s", s, fmt(got), fmt(want));
            end
        end
    endtask

    // Lane 0: RY x3, GREEN x2 (short), YELLOW x3
    task automatic test_short_dwell();
        logic [2:0]  seq [8] = '{LIGHT_RED_YELLOW, LIGHT_RED_YELLOW, LIGHT_RED_YELLOW,
                                 LIGHT_GREEN, LIGHT_GREEN,
                                 LIGHT_YELLOW, LIGHT_YELLOW, LIGHT_YELLOW};
        logic [17:0] v;
        obs_t        got, want;
        do_reset();
        for (int s = 0; s < 8; s++) begin
            v = set_lane(ALL_RED, 0, seq[s]);
            drive_cycle(v, 1'b0, (DWELL_EN && s >= 6) ? exp_fault(s - 6, 3'd4, 3'd0) : exp_ok(v));
            got = observed(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL short_dwell[%0d]: got %s, want %s", s, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_clear();
        logic [17:0] vc, v5, vh;
        logic [17:0] t_lanes [8];
        logic        t_clr   [8];
        obs_t        t_exp   [8];
        obs_t        got, want;
        do_reset();
        vc = set_lane(set_lane(ALL_RED, 1, LIGHT_GREEN), 3, LIGHT_RED_YELLOW);
        v5 = set_lane(ALL_RED, 5, LIGHT_YELLOW);
        vh = set_lane(ALL_RED, 0, LIGHT_RED_YELLOW);
        t_lanes = '{vc, vc, v5, v5, ALL_RED, ALL_RED, ALL_RED, vh};
        t_clr   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        t_exp   = '{exp_ok(vc),
                    exp_fault(0, 3'd2, 3'd1),
                    exp_fault(1, 3'd2, 3'd1),
                    exp_fault(2, 3'd2, 3'd1),   // clear ignored: lane 5 still YELLOW
                    exp_fault(3, 3'd2, 3'd1),   // clear ignored: lane 5 still YELLOW
                    exp_ok(ALL_RED),            // all RED, clean: clear taken
                    exp_ok(ALL_RED),
                    exp_ok(vh)};
        for (int s = 0; s < 8; s++) begin
            drive_cycle(t_lanes[s], t_clr[s], t_exp[s]);
            got = observed(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL clear[%0d]: got %s, want %s", s, fmt(got), fmt(want));
            end
        end
        drv_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [17:0] vc;
        obs_t        got, want;
        do_reset();
        vc = set_lane(set_lane(ALL_RED, 1, LIGHT_GREEN), 3, LIGHT_RED_YELLOW);
        for (int s = 0; s < 6; s++) begin
            drive_cycle(vc, 1'b0, (s == 0) ? exp_ok(vc) : exp_fault(s - 1, 3'd2, 3'd1));
            got = observed(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL async_pre[%0d]: got %s, want %s", s, fmt(got), fmt(want));
            end
        end
        // Mid-cycle, during the dark half of the flash, with no clock edge following
        #3 rst_n = 1'b0;
        sb.push_back(exp_ok(ALL_RED));
        #1;
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL async_reset: got %s, want %s", fmt(got), fmt(want));
        end
        drv_lanes = ALL_RED;
        #1 rst_n = 1'b1;
        drive_cycle(ALL_RED, 1'b0, exp_ok(ALL_RED));
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL async_release: got %s, want %s", fmt(got), fmt(want));
        end
    endtask

    initial begin
        test_reset();
        test_legal_cycle();
        test_conflict();
        test_bad_seq_illegal();
        test_short_dwell();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
